// File: rtl/ctrl_pipeline.sv
// Control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) for the RV32I 5-stage core,
// with branch redirect, load-use stall and EX operand forwarding selects.
module ctrl_pipeline #(
   parameter int REG_ADDR_W = 5,
   parameter int ALUCTRL_W  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_regWrite,
   input  logic                  id_aluSrc,
   input  logic                  id_memWrite,
   input  logic                  id_resultSrc,
   input  logic                  id_branch,
   input  logic [ALUCTRL_W-1:0]  id_aluControl,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  ex_zero,
   output logic                  ex_valid,
   output logic                  ex_regWrite,
   output logic                  ex_aluSrc,
   output logic                  ex_memWrite,
   output logic                  ex_resultSrc,
   output logic                  ex_branch,
   output logic [ALUCTRL_W-1:0]  ex_aluControl,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_regWrite,
   output logic                  mem_memWrite,
   output logic                  mem_resultSrc,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_regWrite,
   output logic                  wb_resultSrc,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  pcSrc,
   output logic                  stall,
   output logic                  flush,
   output logic [1:0]            forwardA,
   output logic [1:0]            forwardB
);

   logic hazard;
   logic bubble;

   assign pcSrc  = ex_valid & ex_branch & ex_zero;
   assign hazard = ex_valid & ex_resultSrc & ex_regWrite & (ex_rd != '0) & id_valid &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   // A taken branch squashes the ID instruction anyway, so it wins over a stall.
   assign stall  = hazard & ~pcSrc;
   assign flush  = pcSrc;
   assign bubble = stall | pcSrc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid      <= 1'b0;
         ex_regWrite   <= 1'b0;
         ex_aluSrc     <= 1'b0;
         ex_memWrite   <= 1'b0;
         ex_resultSrc  <= 1'b0;
         ex_branch     <= 1'b0;
         ex_aluControl <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
      end else if (bubble) begin
         ex_valid      <= 1'b0;
         ex_regWrite   <= 1'b0;
         ex_aluSrc     <= 1'b0;
         ex_memWrite   <= 1'b0;
         ex_resultSrc  <= 1'b0;
         ex_branch     <= 1'b0;
         ex_aluControl <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
      end else begin
         ex_valid      <= id_valid;
         ex_regWrite   <= id_regWrite & id_valid;
         ex_aluSrc     <= id_aluSrc;
         ex_memWrite   <= id_memWrite & id_valid;
         ex_resultSrc  <= id_resultSrc;
         ex_branch     <= id_branch & id_valid;
         ex_aluControl <= id_aluControl;
         ex_rs1        <= id_rs1;
         ex_rs2        <= id_rs2;
         ex_rd         <= id_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_regWrite  <= 1'b0;
         mem_memWrite  <= 1'b0;
         mem_resultSrc <= 1'b0;
         mem_rd        <= '0;
         wb_regWrite   <= 1'b0;
         wb_resultSrc  <= 1'b0;
         wb_rd         <= '0;
      end else begin
         mem_regWrite  <= ex_regWrite;
         mem_memWrite  <= ex_memWrite;
         mem_resultSrc <= ex_resultSrc;
         mem_rd        <= ex_rd;
         wb_regWrite   <= mem_regWrite;
         wb_resultSrc  <= mem_resultSrc;
         wb_rd         <= mem_rd;
      end
   end

   always_comb begin
      forwardA = 2'b00;
      if (mem_regWrite && (mem_rd != '0) && (mem_rd == ex_rs1))
         forwardA = 2'b10;
      else if (wb_regWrite && (wb_rd != '0) && (wb_rd == ex_rs1))
         forwardA = 2'b01;
   end

   always_comb begin
      forwardB = 2'b00;
      if (mem_regWrite && (mem_rd != '0) && (mem_rd == ex_rs2))
         forwardB = 2'b10;
      else if (wb_regWrite && (wb_rd != '0) && (wb_rd == ex_rs2))
         forwardB = 2'b01;
   end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Randomized bench for ctrl_pipeline against a stage-list reference model,
// including mid-stream asynchronous resets.
`timescale 1ns/1ps
module tb_ctrl_pipeline;

   typedef struct packed {
      logic       v;
      logic       rw;
      logic       as;
      logic       mw;
      logic       rsrc;
      logic       br;
      logic [2:0] alu;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } instr_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0, id_regWrite = 1'b0, id_aluSrc = 1'b0, id_memWrite = 1'b0;
   logic       id_resultSrc = 1'b0, id_branch = 1'b0, ex_zero = 1'b0;
   logic [2:0] id_aluControl = '0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic       ex_valid, ex_regWrite, ex_aluSrc, ex_memWrite, ex_resultSrc, ex_branch;
   logic [2:0] ex_aluControl;
   logic [4:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       mem_regWrite, mem_memWrite, mem_resultSrc, wb_regWrite, wb_resultSrc;
   logic       pcSrc, stall, flush;
   logic [1:0] forwardA, forwardB;

   int n_checks = 0;
   int n_errors = 0;

   ctrl_pipeline #(.REG_ADDR_W(5), .ALUCTRL_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_regWrite(id_regWrite), .id_aluSrc(id_aluSrc),
      .id_memWrite(id_memWrite), .id_resultSrc(id_resultSrc), .id_branch(id_branch),
      .id_aluControl(id_aluControl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .ex_zero(ex_zero),
      .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_aluSrc(ex_aluSrc),
      .ex_memWrite(ex_memWrite), .ex_resultSrc(ex_resultSrc), .ex_branch(ex_branch),
      .ex_aluControl(ex_aluControl), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .mem_regWrite(mem_regWrite), .mem_memWrite(mem_memWrite),
      .mem_resultSrc(mem_resultSrc), .mem_rd(mem_rd),
      .wb_regWrite(wb_regWrite), .wb_resultSrc(wb_resultSrc), .wb_rd(wb_rd),
      .pcSrc(pcSrc), .stall(stall), .flush(flush),
      .forwardA(forwardA), .forwardB(forwardB)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; older instructions sit at higher index.
   instr_t pipe [3];
   instr_t id_i;

   function automatic logic [1:0] fwd_model(input logic [4:0] rs, input instr_t mem_i,
                                            input instr_t wb_i);
      instr_t producers [2];
      producers[0] = mem_i;  // youngest producer first
      producers[1] = wb_i;
      if (rs == 5'd0) return 2'b00;
      for (int k = 0; k < 2; k++)
         if (producers[k].rw && producers[k].rd == rs) return (k == 0) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   task automatic check_regs();
      chk("ex_valid", 32'(ex_valid), 32'(pipe[0].v));
      chk("ex_regWrite", 32'(ex_regWrite), 32'(pipe[0].rw));
      chk("ex_aluSrc", 32'(ex_aluSrc), 32'(pipe[0].as));
      chk("ex_memWrite", 32'(ex_memWrite), 32'(pipe[0].mw));
      chk("ex_resultSrc", 32'(ex_resultSrc), 32'(pipe[0].rsrc));
      chk("ex_branch", 32'(ex_branch), 32'(pipe[0].br));
      chk("ex_aluControl", 32'(ex_aluControl), 32'(pipe[0].alu));
      chk("ex_rs1", 32'(ex_rs1), 32'(pipe[0].rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(pipe[0].rs2));
      chk("ex_rd", 32'(ex_rd), 32'(pipe[0].rd));
      chk("mem_regWrite", 32'(mem_regWrite), 32'(pipe[1].rw));
      chk("mem_memWrite", 32'(mem_memWrite), 32'(pipe[1].mw));
      chk("mem_resultSrc", 32'(mem_resultSrc), 32'(pipe[1].rsrc));
      chk("mem_rd", 32'(mem_rd), 32'(pipe[1].rd));
      chk("wb_regWrite", 32'(wb_regWrite), 32'(pipe[2].rw));
      chk("wb_resultSrc", 32'(wb_resultSrc), 32'(pipe[2].rsrc));
      chk("wb_rd", 32'(wb_rd), 32'(pipe[2].rd));
   endtask

   function automatic logic [4:0] rand_reg();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 3));
   endfunction

   task automatic new_id();
      id_i.v    = ($urandom_range(0, 99) < 85);
      id_i.rw   = ($urandom_range(0, 99) < 70);
      id_i.as   = 1'($urandom_range(0, 1));
      id_i.mw   = ($urandom_range(0, 99) < 20);
      id_i.rsrc = ($urandom_range(0, 99) < 40);
      id_i.br   = ($urandom_range(0, 99) < 25);
      id_i.alu  = 3'($urandom_range(0, 7));
      id_i.rs1  = rand_reg();
      id_i.rs2  = rand_reg();
      id_i.rd   = rand_reg();
   endtask

   task automatic drive_id();
      id_valid = id_i.v; id_regWrite = id_i.rw; id_aluSrc = id_i.as;
      id_memWrite = id_i.mw; id_resultSrc = id_i.rsrc; id_branch = id_i.br;
      id_aluControl = id_i.alu; id_rs1 = id_i.rs1; id_rs2 = id_i.rs2; id_rd = id_i.rd;
   endtask

   initial begin
      logic   held;
      logic   taken, load_use, exp_stall;
      instr_t cap;
      int     n_resets;
      held = 1'b0;
      n_resets = 0;
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      id_i = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_regs();
      chk("rst_pcSrc", 32'(pcSrc), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      rst_n = 1'b1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         rst_n = 1'b1;
         check_regs();
         if (!held) new_id();
         drive_id();
         ex_zero = 1'($urandom_range(0, 1));
         #1;
         // Branch resolves on the instruction in EX; load-use needs a load there feeding ID.
         taken    = pipe[0].v && pipe[0].br && ex_zero;
         load_use = pipe[0].v && pipe[0].rsrc && pipe[0].rw && pipe[0].rd != 5'd0 && id_i.v &&
                    (pipe[0].rd == id_i.rs1 || pipe[0].rd == id_i.rs2);
         exp_stall = load_use && !taken;
         chk("pcSrc", 32'(pcSrc), 32'(taken));
         chk("flush", 32'(flush), 32'(taken));
         chk("stall", 32'(stall), 32'(exp_stall));
         chk("forwardA", 32'(forwardA), 32'(fwd_model(pipe[0].rs1, pipe[1], pipe[2])));
         chk("forwardB", 32'(forwardB), 32'(fwd_model(pipe[0].rs2, pipe[1], pipe[2])));

         cap = id_i;
         if (!cap.v) begin
            cap.rw = 1'b0; cap.mw = 1'b0; cap.br = 1'b0;
         end
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = (taken || exp_stall) ? instr_t'(0) : cap;
         held = exp_stall;

         if (cyc > 20 && $urandom_range(0, 59) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst", 32'({ex_valid, ex_regWrite, ex_memWrite, ex_branch, ex_resultSrc,
                                  ex_rd, mem_regWrite, mem_memWrite, mem_rd,
                                  wb_regWrite, wb_rd}), 32'd0);
            for (int s = 0; s < 3; s++) pipe[s] = '0;
            held = 1'b0;
            n_resets++;
         end
      end

      if (n_resets == 0) chk("reset_exercised", 32'(n_resets), 32'd1);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
